// File: rtl/traffic_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : traffic_sensor_conditioner
// Brief   : Debounces the side-road detector and times the sb request.
// Revision: 1.0 - initial release
// ============================================================================
module traffic_sensor_conditioner #(
  parameter int DEB_CYCLES = 4,
  parameter int ARM_CYCLES = 8,
  parameter int MIN_HOLD   = 16,
  parameter int GAP_CYCLES = 8,
  parameter int MAX_HOLD   = 64,
  parameter int LOCKOUT    = 32,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sensor_raw,
  input  logic             cnt_clr,
  output logic             sb,
  output logic             forced_drop,
  output logic [CNT_W-1:0] veh_count,
  output logic [1:0]       state_o
);

  localparam int c_M1 = (MAX_HOLD > LOCKOUT) ? MAX_HOLD : LOCKOUT;
  localparam int c_M2 = (c_M1 > ARM_CYCLES) ? c_M1 : ARM_CYCLES;
  localparam int c_M3 = (c_M2 > GAP_CYCLES) ? c_M2 : GAP_CYCLES;
  localparam int c_TW = $clog2(c_M3 + 1);
  localparam int c_DW = $clog2(DEB_CYCLES + 1);

  localparam logic [c_DW-1:0] c_DEB_LAST  = c_DW'(DEB_CYCLES - 1);
  localparam logic [c_TW-1:0] c_ARM_LAST  = c_TW'(ARM_CYCLES - 1);
  localparam logic [c_TW-1:0] c_MIN_LAST  = c_TW'(MIN_HOLD - 1);
  localparam logic [c_TW-1:0] c_MAX_LAST  = c_TW'(MAX_HOLD - 1);
  localparam logic [c_TW-1:0] c_LOCK_LAST = c_TW'(LOCKOUT - 1);
  localparam logic [c_TW-1:0] c_GAP       = c_TW'(GAP_CYCLES);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ARMING  = 2'd1;
  localparam logic [1:0] c_HOLD    = 2'd2;
  localparam logic [1:0] c_LOCKOUT = 2'd3;

  logic [1:0]       r_sync;
  logic             r_deb;
  logic             r_deb_d;
  logic [c_DW-1:0]  r_deb_cnt;
  logic [CNT_W-1:0] r_veh;
  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [c_TW-1:0]  r_timer;
  logic [c_TW-1:0]  r_gap;
  logic [c_TW-1:0]  w_gap_cnt;
  logic             w_max_hit;
  logic             w_rise;
  logic             r_sb;
  logic             r_fd;
  logic             w_sb_next;
  logic             w_fd_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= 2'b00;
      r_deb     <= 1'b0;
      r_deb_d   <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync  <= {r_sync[0], sensor_raw};
      r_deb_d <= r_deb;
      if (r_sync[1] == r_deb) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == c_DEB_LAST) begin
        r_deb     <= r_sync[1];
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + 1'b1;
      end
    end
  end

  assign w_rise = r_deb & ~r_deb_d;

  // Clear wins over a coincident arrival; the arrival is simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_veh <= '0;
    end else if (cnt_clr) begin
      r_veh <= '0;
    end else if (w_rise && (r_veh != '1)) begin
      r_veh <= r_veh + 1'b1;
    end
  end

  assign w_gap_cnt = r_deb ? '0 : ((r_gap == '1) ? r_gap : r_gap + 1'b1);
  assign w_max_hit = (r_state == c_HOLD) && (r_timer == c_MAX_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_sb    <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_sb    <= w_sb_next;
      r_fd    <= w_fd_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:    if (r_deb) w_next = c_ARMING;
      c_ARMING: begin
        if (!r_deb)                     w_next = c_IDLE;
        else if (r_timer == c_ARM_LAST) w_next = c_HOLD;
      end
      c_HOLD: begin
        if (w_max_hit)                                          w_next = c_LOCKOUT;
        else if ((r_timer >= c_MIN_LAST) && (w_gap_cnt >= c_GAP)) w_next = c_LOCKOUT;
      end
      c_LOCKOUT: if (r_timer == c_LOCK_LAST) w_next = c_IDLE;
      default:   w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_sb_next = (w_next == c_HOLD);
    w_fd_next = w_max_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer <= '0;
      r_gap   <= '0;
    end else begin
      if (w_next != r_state)  r_timer <= '0;
      else if (r_timer != '1) r_timer <= r_timer + 1'b1;
      r_gap <= ((r_state == c_HOLD) && (w_next == c_HOLD)) ? w_gap_cnt : '0;
    end
  end

  assign sb          = r_sb;
  assign forced_drop = r_fd;
  assign veh_count   = r_veh;
  assign state_o     = r_state;

endmodule
`default_nettype wire
